// File: rtl/sram_pkg.sv
// sram_pkg: constants and types shared by the block mover and the SRAM it drives.
package sram_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int LEN_W  = ADDR_W + 1;

    localparam logic OP_COPY = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } moverState_e;

endpackage

// File: rtl/sram_block_mover.sv
// sram_block_mover: host-commanded COPY/FILL engine that is the sole initiator
// on the single-port synchronous SRAM. One byte moves per RD/WR pair (COPY)
// or per WR cycle (FILL), always in ascending address order.
module sram_block_mover
    import sram_pkg::*;
#(
    parameter int ADDR_W = sram_pkg::ADDR_W,
    parameter int DATA_W = sram_pkg::DATA_W,
    parameter int LEN_W  = sram_pkg::LEN_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Op,
    input  logic [ADDR_W-1:0] Src_Addr,
    input  logic [ADDR_W-1:0] Dst_Addr,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] Fill_Value,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_RW,
    output logic              Mem_En,
    output logic [DATA_W-1:0] Mem_Data_In,
    input  logic [DATA_W-1:0] Mem_Data_Out
);

    moverState_e       state_q;
    logic              opFill_q;
    logic [ADDR_W-1:0] srcAddr_q;
    logic [ADDR_W-1:0] dstAddr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic [DATA_W-1:0] fillValue_q;

    logic [LEN_W-1:0]  idx_d;
    logic              lastByte;
    logic [ADDR_W-1:0] idxOffset;

    // The index is wider than the address so lengths beyond the SRAM size
    // count correctly; only its low bits form the wrapping address offset.
    assign idx_d     = idx_q + LEN_W'(1);
    assign lastByte  = (idx_q == (len_q - LEN_W'(1)));
    assign idxOffset = idx_q[ADDR_W-1:0];

    assign Busy = (state_q == RD) || (state_q == WR);
    assign Done = (state_q == DONE);

    // Command sequencer: latches the command in IDLE, then steps RD/WR until the last byte or an abort.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= IDLE;
            opFill_q    <= OP_COPY;
            srcAddr_q   <= '0;
            dstAddr_q   <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            fillValue_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        opFill_q    <= Op;
                        srcAddr_q   <= Src_Addr;
                        dstAddr_q   <= Dst_Addr;
                        len_q       <= Len;
                        fillValue_q <= Fill_Value;
                        idx_q       <= '0;
                        if (Len == '0) begin
                            state_q <= DONE;
                        end else if (Op == OP_FILL) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    if (Abort) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (Abort) begin
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_d;
                        if (lastByte) begin
                            state_q <= DONE;
                        end else if (opFill_q == OP_FILL) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // SRAM request decode; in a COPY write the data comes straight from the read issued on the previous edge.
    always_comb begin
        Mem_En      = 1'b0;
        Mem_RW      = 1'b0;
        Mem_Addr    = '0;
        Mem_Data_In = '0;
        case (state_q)
            RD: begin
                Mem_En   = 1'b1;
                Mem_RW   = 1'b0;
                Mem_Addr = srcAddr_q + idxOffset;
            end
            WR: begin
                Mem_En      = 1'b1;
                Mem_RW      = 1'b1;
                Mem_Addr    = dstAddr_q + idxOffset;
                Mem_Data_In = (opFill_q == OP_FILL) ? fillValue_q : Mem_Data_Out;
            end
            default: begin
                Mem_En      = 1'b0;
                Mem_RW      = 1'b0;
                Mem_Addr    = '0;
                Mem_Data_In = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_block_mover.sv
// tb_sram_block_mover: directed bench for the block mover driving a behavioural
// 32K x 8 synchronous SRAM.
module tb_sram_block_mover;
   import sram_pkg::*;

   logic              Clk;
   logic              Rst;
   logic              Start;
   logic              Op;
   logic [ADDR_W-1:0] Src_Addr;
   logic [ADDR_W-1:0] Dst_Addr;
   logic [LEN_W-1:0]  Len;
   logic [DATA_W-1:0] Fill_Value;
   logic              Abort;
   logic              Busy;
   logic              Done;
   logic [ADDR_W-1:0] Mem_Addr;
   logic              Mem_RW;
   logic              Mem_En;
   logic [DATA_W-1:0] Mem_Data_In;
   logic [DATA_W-1:0] Mem_Data_Out;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic              sramReset;
   logic              clearMem;
   logic              bkWrEn;
   logic [ADDR_W-1:0] bkAddr;
   logic [DATA_W-1:0] bkData;

   int errors = 0;
   int checks = 0;

   int doneAt;
   int enCount;
   int busyCount;
   int rwBad;
   int bothBad;

   sram_block_mover dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Start        (Start),
      .Op           (Op),
      .Src_Addr     (Src_Addr),
      .Dst_Addr     (Dst_Addr),
      .Len          (Len),
      .Fill_Value   (Fill_Value),
      .Abort        (Abort),
      .Busy         (Busy),
      .Done         (Done),
      .Mem_Addr     (Mem_Addr),
      .Mem_RW       (Mem_RW),
      .Mem_En       (Mem_En),
      .Mem_Data_In  (Mem_Data_In),
      .Mem_Data_Out (Mem_Data_Out)
   );

   // Free-running clock, 10 time units per period
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   assign sramReset = ~Rst;

   // SRAM array: bench clear and backdoor preload take priority over bus writes
   always @(posedge Clk) begin
      if (clearMem) begin
         for (int a = 0; a < (1 << ADDR_W); a++) mem[a] <= '0;
      end else if (bkWrEn) begin
         mem[bkAddr] <= bkData;
      end else if (Mem_En && Mem_RW) begin
         mem[Mem_Addr] <= Mem_Data_In;
      end
   end

   // SRAM read port: registered data one cycle after a sampled read, zero otherwise
   always @(posedge Clk or posedge sramReset) begin
      if (sramReset) begin
         Mem_Data_Out <= '0;
      end else if (Mem_En && !Mem_RW) begin
         Mem_Data_Out <= mem[Mem_Addr];
      end else begin
         Mem_Data_Out <= '0;
      end
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Write one byte into the SRAM behind the mover's back
   task automatic preload(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      bkWrEn = 1'b1;
      bkAddr = addr;
      bkData = data;
      tick();
      bkWrEn = 1'b0;
   endtask

   // Issue a command, scramble the inputs afterwards, then watch it cycle by cycle
   task automatic applyStimulus(input logic op, input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                                input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] fill,
                                input int abortAt, input int restartAt, input int maxCycles,
                                output int dAt, output int enC, output int busyC, output int rwB, output int bothB);
      Op         = op;
      Src_Addr   = src;
      Dst_Addr   = dst;
      Len        = len;
      Fill_Value = fill;
      Start      = 1'b1;
      tick();
      Start      = 1'b0;
      Op         = ~op;
      Src_Addr   = 15'h5555;
      Dst_Addr   = 15'h2AAA;
      Len        = 16'd7;
      Fill_Value = 8'hFF;
      dAt   = -1;
      enC   = 0;
      busyC = 0;
      rwB   = 0;
      bothB = 0;
      for (int j = 0; j < maxCycles; j++) begin
         if (Mem_En) enC++;
         if (Busy) busyC++;
         if (op == OP_COPY && Mem_En && (Mem_RW !== ((j % 2) == 1))) rwB++;
         if (Busy && Done) bothB++;
         if (Done && dAt < 0) dAt = j;
         if (j == abortAt) Abort = 1'b1;
         if (j == restartAt) begin
            Start      = 1'b1;
            Op         = OP_COPY;
            Dst_Addr   = 15'h0300;
            Len        = 16'd1;
            Fill_Value = 8'hEE;
         end
         tick();
         Abort = 1'b0;
         Start = 1'b0;
         if (dAt >= 0) break;
      end
   endtask

   // Directed test sequence
   initial begin
      Rst        = 1'b0;
      Start      = 1'b1;
      Op         = OP_FILL;
      Src_Addr   = 15'h1234;
      Dst_Addr   = 15'h4321;
      Len        = 16'd9;
      Fill_Value = 8'h5A;
      Abort      = 1'b0;
      clearMem   = 1'b1;
      bkWrEn     = 1'b0;
      bkAddr     = '0;
      bkData     = '0;
      tick();
      tick();
      clearMem = 1'b0;

      checkOutput("reset_busy", 32'(Busy), 32'd0);
      checkOutput("reset_done", 32'(Done), 32'd0);
      checkOutput("reset_en", 32'(Mem_En), 32'd0);
      checkOutput("reset_rw", 32'(Mem_RW), 32'd0);
      checkOutput("reset_addr", 32'(Mem_Addr), 32'd0);
      checkOutput("reset_din", 32'(Mem_Data_In), 32'd0);

      Start = 1'b0;
      Rst   = 1'b1;
      tick();

      // FILL of four bytes
      applyStimulus(OP_FILL, 15'h0000, 15'h0010, 16'd4, 8'hA5, -1, -1, 50, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("fill_done_at", 32'(doneAt), 32'd4);
      checkOutput("fill_busy_cycles", 32'(busyCount), 32'd4);
      checkOutput("fill_en_cycles", 32'(enCount), 32'd4);
      checkOutput("fill_busy_and_done", 32'(bothBad), 32'd0);
      checkOutput("fill_done_one_cycle", 32'(Done), 32'd0);
      checkOutput("fill_m10", 32'(mem[15'h0010]), 32'hA5);
      checkOutput("fill_m11", 32'(mem[15'h0011]), 32'hA5);
      checkOutput("fill_m12", 32'(mem[15'h0012]), 32'hA5);
      checkOutput("fill_m13", 32'(mem[15'h0013]), 32'hA5);
      checkOutput("fill_m14", 32'(mem[15'h0014]), 32'h00);

      // COPY of three preloaded bytes
      preload(15'h0100, 8'h11);
      preload(15'h0101, 8'h22);
      preload(15'h0102, 8'h33);
      applyStimulus(OP_COPY, 15'h0100, 15'h0200, 16'd3, 8'h00, -1, -1, 50, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("copy_done_at", 32'(doneAt), 32'd6);
      checkOutput("copy_en_cycles", 32'(enCount), 32'd6);
      checkOutput("copy_busy_cycles", 32'(busyCount), 32'd6);
      checkOutput("copy_rw_alternate", 32'(rwBad), 32'd0);
      checkOutput("copy_m200", 32'(mem[15'h0200]), 32'h11);
      checkOutput("copy_m201", 32'(mem[15'h0201]), 32'h22);
      checkOutput("copy_m202", 32'(mem[15'h0202]), 32'h33);
      checkOutput("copy_m203", 32'(mem[15'h0203]), 32'h00);

      // FILL across the top of the address space
      applyStimulus(OP_FILL, 15'h0000, 15'h7FFE, 16'd4, 8'h5C, -1, -1, 50, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("wrap_done_at", 32'(doneAt), 32'd4);
      checkOutput("wrap_m7ffe", 32'(mem[15'h7FFE]), 32'h5C);
      checkOutput("wrap_m7fff", 32'(mem[15'h7FFF]), 32'h5C);
      checkOutput("wrap_m0000", 32'(mem[15'h0000]), 32'h5C);
      checkOutput("wrap_m0001", 32'(mem[15'h0001]), 32'h5C);
      checkOutput("wrap_m0002", 32'(mem[15'h0002]), 32'h00);

      // Overlapping COPY replicates the source byte
      preload(15'h0040, 8'h77);
      applyStimulus(OP_COPY, 15'h0040, 15'h0041, 16'd3, 8'h00, -1, -1, 50, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("ovl_done_at", 32'(doneAt), 32'd6);
      checkOutput("ovl_m41", 32'(mem[15'h0041]), 32'h77);
      checkOutput("ovl_m42", 32'(mem[15'h0042]), 32'h77);
      checkOutput("ovl_m43", 32'(mem[15'h0043]), 32'h77);
      checkOutput("ovl_m44", 32'(mem[15'h0044]), 32'h00);

      // Zero-length command
      applyStimulus(OP_FILL, 15'h0000, 15'h0050, 16'd0, 8'hCC, -1, -1, 10, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("len0_done_at", 32'(doneAt), 32'd0);
      checkOutput("len0_en_cycles", 32'(enCount), 32'd0);
      checkOutput("len0_busy_cycles", 32'(busyCount), 32'd0);
      checkOutput("len0_m50", 32'(mem[15'h0050]), 32'h00);

      // Start while busy is ignored
      applyStimulus(OP_FILL, 15'h0000, 15'h0300, 16'd5, 8'h3C, -1, 2, 50, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("restart_done_at", 32'(doneAt), 32'd5);
      checkOutput("restart_m300", 32'(mem[15'h0300]), 32'h3C);
      checkOutput("restart_m304", 32'(mem[15'h0304]), 32'h3C);
      checkOutput("restart_m305", 32'(mem[15'h0305]), 32'h00);
      checkOutput("restart_idle_busy", 32'(Busy), 32'd0);

      // Abort a long FILL right after its tenth write
      applyStimulus(OP_FILL, 15'h0000, 15'h0500, 16'd100, 8'h99, 9, -1, 20, doneAt, enCount, busyCount, rwBad, bothBad);
      checkOutput("abort_no_done", 32'(doneAt), 32'hFFFF_FFFF);
      checkOutput("abort_en_cycles", 32'(enCount), 32'd10);
      checkOutput("abort_busy_cycles", 32'(busyCount), 32'd10);
      checkOutput("abort_m500", 32'(mem[15'h0500]), 32'h99);
      checkOutput("abort_m509", 32'(mem[15'h0509]), 32'h99);
      checkOutput("abort_m50a", 32'(mem[15'h050A]), 32'h00);

      // Asynchronous reset in the middle of a COPY
      Op       = OP_COPY;
      Src_Addr = 15'h0100;
      Dst_Addr = 15'h0600;
      Len      = 16'd3;
      Start    = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      tick();
      checkOutput("rst_pre_busy", 32'(Busy), 32'd1);
      checkOutput("rst_pre_en", 32'(Mem_En), 32'd1);
      #2;
      Rst = 1'b0;
      #1;
      checkOutput("rst_mid_en", 32'(Mem_En), 32'd0);
      checkOutput("rst_mid_busy", 32'(Busy), 32'd0);
      checkOutput("rst_mid_done", 32'(Done), 32'd0);
      checkOutput("rst_mid_addr", 32'(Mem_Addr), 32'd0);
      checkOutput("rst_mid_rw", 32'(Mem_RW), 32'd0);
      checkOutput("rst_mid_din", 32'(Mem_Data_In), 32'd0);
      tick();
      Rst = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("rst_after_busy", 32'(Busy), 32'd0);
      checkOutput("rst_after_en", 32'(Mem_En), 32'd0);
      checkOutput("rst_m600", 32'(mem[15'h0600]), 32'h11);
      checkOutput("rst_m601", 32'(mem[15'h0601]), 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
